vjtag_dr_bank: RTL and testbench

Parametrised data-register bank for the virtual JTAG hub: consumes the TAP state strobes and IR value presented by the virtual JTAG megafunction and implements `NUM_CH` independent `DR_WIDTH`-bit scan registers, plus a 1-bit bypass register. It sits directly between the virtual JTAG instance and user logic, capturing parallel data from user logic on Capture-DR and delivering shifted-in data with a one-cycle strobe on Update-DR. It adds scan-length checking and a status word returned through the IR capture path.

---
 rtl/vjtag_dr_bank.sv | 145 ++++++++++++++
 tb/tb_vjtag_dr_bank.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vjtag_dr_bank.sv
// Virtual JTAG data-register bank: NUM_CH scan registers plus bypass, with
// scan-length checking and a status word returned through the IR capture path.

module vjtag_dr_ch #(
  parameter int DR_WIDTH = 32
) (
  input  logic                tck,
  input  logic                rst_n,
  input  logic                we,
  input  logic [DR_WIDTH-1:0] d,
  output logic [DR_WIDTH-1:0] q,
  output logic                stb
);
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      stb <= 1'b0;
    end else begin
      stb <= we;
      if (we) q <= d;
    end
  end
endmodule

module vjtag_dr_bank #(
  parameter int IR_WIDTH = 10,
  parameter int DR_WIDTH = 32,
  parameter int NUM_CH   = 4
) (
  input  logic                       tck,
  input  logic                       rst_n,
  input  logic                       tdi,
  output logic                       tdo,
  input  logic [IR_WIDTH-1:0]        ir_in,
  output logic [IR_WIDTH-1:0]        ir_out,
  input  logic                       virtual_state_cdr,
  input  logic                       virtual_state_sdr,
  input  logic                       virtual_state_e1dr,
  input  logic                       virtual_state_pdr,
  input  logic                       virtual_state_e2dr,
  input  logic                       virtual_state_udr,
  input  logic                       virtual_state_cir,
  input  logic                       virtual_state_uir,
  input  logic [NUM_CH*DR_WIDTH-1:0] cap_data,
  output logic [NUM_CH*DR_WIDTH-1:0] upd_data,
  output logic [NUM_CH-1:0]          upd_strobe
);
  localparam int CNT_W = $clog2(DR_WIDTH + 2);
  localparam int UC_W  = IR_WIDTH - 2;
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(DR_WIDTH);
  localparam logic [CNT_W-1:0]    CNT_SAT  = CNT_W'(DR_WIDTH + 1);
  localparam logic [IR_WIDTH-1:0] NCH_V    = IR_WIDTH'(NUM_CH);

  logic [DR_WIDTH-1:0] sr;
  logic                byp;
  logic                byp_sel;
  logic [IR_WIDTH-1:0] ch_q;
  logic [CNT_W-1:0]    cnt;
  logic                err;
  logic                seen;
  logic [UC_W-1:0]     upd_cnt;

  logic [NUM_CH-1:0][DR_WIDTH-1:0] cap_arr;
  logic [NUM_CH-1:0][DR_WIDTH-1:0] upd_arr;
  logic [NUM_CH-1:0]               we;
  logic [DR_WIDTH-1:0]             cap_sel;
  logic                            sel_ch;
  logic                            upd_ok;
  logic                            hold_st;

  assign cap_arr = cap_data;
  assign upd_data = upd_arr;
  assign sel_ch  = (ir_in < NCH_V);
  assign upd_ok  = virtual_state_udr && !byp_sel && (cnt == CNT_FULL);
  // Pause/exit states and Capture-IR leave every register untouched.
  assign hold_st = virtual_state_e1dr | virtual_state_pdr | virtual_state_e2dr |
                   virtual_state_cir;

  always_comb begin
    cap_sel = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (ir_in == IR_WIDTH'(k)) cap_sel = cap_arr[k];
  end

  always_comb begin
    we = '0;
    for (int k = 0; k < NUM_CH; k++)
      we[k] = upd_ok && (ch_q == IR_WIDTH'(k));
  end

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      vjtag_dr_ch #(.DR_WIDTH(DR_WIDTH)) u_ch (
        .tck   (tck),
        .rst_n (rst_n),
        .we    (we[k]),
        .d     (sr),
        .q     (upd_arr[k]),
        .stb   (upd_strobe[k])
      );
    end
  endgenerate

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      byp     <= 1'b0;
      byp_sel <= 1'b0;
      ch_q    <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      seen    <= 1'b0;
      upd_cnt <= '0;
    end else if (!hold_st) begin
      if (virtual_state_cdr) begin
        ch_q    <= ir_in;
        byp_sel <= !sel_ch;
        cnt     <= '0;
        if (sel_ch) sr <= cap_sel;
        else        byp <= 1'b0;
      end
      if (virtual_state_sdr) begin
        if (byp_sel) byp <= tdi;
        else         sr  <= {tdi, sr[DR_WIDTH-1:1]};
        if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      end
      // A scan that shifted nothing is a plain capture, not a length error.
      if (virtual_state_udr && !byp_sel) begin
        if (cnt == CNT_FULL) begin
          upd_cnt <= upd_cnt + 1'b1;
          seen    <= 1'b1;
        end else if (cnt != '0) begin
          err <= 1'b1;
        end
      end
      if (virtual_state_uir) begin
        err  <= 1'b0;
        seen <= 1'b0;
      end
    end
  end

  assign tdo    = byp_sel ? byp : sr[0];
  assign ir_out = {upd_cnt, seen, err};
endmodule

// File: tb/tb_vjtag_dr_bank.sv
// Directed bench for vjtag_dr_bank: a queue-based scan model checked every
// cycle, plus literal expectations at the key points of each scenario.

module tb_vjtag_dr_bank;
  localparam int IRW = 10;
  localparam int DRW = 32;
  localparam int NCH = 4;

  localparam int S_IDLE = 0, S_CDR = 1, S_SDR = 2, S_E1 = 3, S_PDR = 4,
                 S_E2 = 5, S_UDR = 6, S_CIR = 7, S_UIR = 8;

  logic               tck = 0;
  logic               rst_n = 1;
  logic               tdi = 0;
  logic [IRW-1:0]     ir_in = '0;
  logic               cdr = 0, sdr = 0, e1dr = 0, pdr = 0, e2dr = 0, udr = 0, cir = 0, uir = 0;
  logic [NCH*DRW-1:0] cap_data = '0;
  logic               tdo;
  logic [IRW-1:0]     ir_out;
  logic [NCH*DRW-1:0] upd_data;
  logic [NCH-1:0]     upd_strobe;

  vjtag_dr_bank #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .NUM_CH(NCH)) dut (
    .tck(tck), .rst_n(rst_n), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
    .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_e1dr(e1dr),
    .virtual_state_pdr(pdr), .virtual_state_e2dr(e2dr), .virtual_state_udr(udr),
    .virtual_state_cir(cir), .virtual_state_uir(uir),
    .cap_data(cap_data), .upd_data(upd_data), .upd_strobe(upd_strobe)
  );

  always #5 tck = ~tck;

  // Model: the scan path is a FIFO whose head is tdo; the shifted-in bits are
  // kept separately so an exact-length scan can be reassembled into a word.
  int             m_ch;
  bit             m_q[$];
  bit             m_in[$];
  int             m_n;
  logic [DRW-1:0] m_upd[NCH];
  bit             m_err, m_seen;
  logic [7:0]     m_ucnt;
  logic [NCH-1:0] m_stb;
  bit             chk_en = 0;
  int             n_tests = 0, n_fail = 0;
  logic [NCH*DRW-1:0] exp_upd;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_ch = 0;
    m_q.delete();
    for (int i = 0; i < DRW; i++) m_q.push_back(1'b0);
    m_in.delete();
    m_n = 0;
    for (int k = 0; k < NCH; k++) m_upd[k] = '0;
    m_err = 0; m_seen = 0; m_ucnt = '0; m_stb = '0;
  endtask

  always @(negedge tck) begin
    if (chk_en) begin
      for (int k = 0; k < NCH; k++) exp_upd[k*DRW +: DRW] = m_upd[k];
      check("tdo", 128'(tdo), 128'(m_q[0]));
      check("ir_out", 128'(ir_out), 128'({m_ucnt, m_seen, m_err}));
      check("upd_data", 128'(upd_data), 128'(exp_upd));
      check("upd_strobe", 128'(upd_strobe), 128'(m_stb));
    end
  end

  task automatic set_st(int st);
    {cdr, sdr, e1dr, pdr, e2dr, udr, cir, uir} = '0;
    case (st)
      S_CDR: cdr = 1;  S_SDR: sdr = 1;  S_E1: e1dr = 1; S_PDR: pdr = 1;
      S_E2:  e2dr = 1; S_UDR: udr = 1;  S_CIR: cir = 1; S_UIR: uir = 1;
      default: ;
    endcase
  endtask

  task automatic step(int st, bit t);
    logic [DRW-1:0] w;
    set_st(st);
    tdi = t;
    @(posedge tck);
    m_stb = '0;
    if (rst_n) begin
      case (st)
        S_CDR: begin
          m_ch = (ir_in < NCH) ? int'(ir_in) : -1;
          m_q.delete(); m_in.delete(); m_n = 0;
          if (m_ch >= 0) for (int i = 0; i < DRW; i++) m_q.push_back(cap_data[m_ch*DRW + i]);
          else m_q.push_back(1'b0);
        end
        S_SDR: begin
          m_q.push_back(t);
          void'(m_q.pop_front());
          m_in.push_back(t);
          m_n++;
        end
        S_UDR: if (m_ch >= 0) begin
          if (m_n == DRW) begin
            for (int i = 0; i < DRW; i++) w[i] = m_in[i];
            m_upd[m_ch] = w;
            m_stb[m_ch] = 1'b1;
            m_ucnt++;
            m_seen = 1;
          end else if (m_n != 0) m_err = 1;
        end
        S_UIR: begin m_err = 0; m_seen = 0; end
        default: ;
      endcase
    end
    @(negedge tck);
  endtask

  task automatic do_reset();
    #1 rst_n = 0;
    m_reset();
    chk_en = 1;
    for (int i = 0; i < 4; i++) begin
      ir_in = IRW'($urandom);
      tdi = 1'($urandom);
      cap_data = {$urandom, $urandom, $urandom, $urandom};
      set_st(int'($urandom_range(0, 8)));
      @(negedge tck);
    end
    set_st(S_IDLE);
    #1 rst_n = 1;
  endtask

  // Capture, shift nsdr bits of word (zeros past DRW), stop in Exit1-DR.
  task automatic scan(int ch_ir, logic [DRW-1:0] cap, logic [DRW-1:0] word, int nsdr,
                      output logic [DRW-1:0] tdo_seen);
    tdo_seen = '0;
    ir_in = IRW'(ch_ir);
    if (ch_ir < NCH) cap_data[ch_ir*DRW +: DRW] = cap;
    step(S_CDR, 0);
    for (int i = 0; i < nsdr; i++) begin
      if (i < DRW) tdo_seen[i] = tdo;
      step(S_SDR, (i < DRW) ? word[i] : 1'b0);
    end
    step(S_E1, 0);
  endtask

  logic [DRW-1:0] tw;
  logic [3:0]     bt;

  initial begin
    @(negedge tck);
    do_reset();
    check("reset tdo", 128'(tdo), 128'(0));
    check("reset ir_out", 128'(ir_out), 128'(0));
    check("reset upd_data", 128'(upd_data), 128'(0));
    for (int i = 0; i < 3; i++) step(S_IDLE, 0);

    // Channel 2 full-length scan.
    scan(2, 32'hDEADBEEF, 32'h12345678, 32, tw);
    check("ch2 tdo stream", 128'(tw), 128'(32'hDEADBEEF));
    step(S_UDR, 0);
    check("ch2 strobe", 128'(upd_strobe), 128'(4'b0100));
    check("ch2 upd_data", 128'(upd_data[95:64]), 128'(32'h12345678));
    check("ch2 ir_out", 128'(ir_out), 128'(10'b110));
    step(S_IDLE, 0);
    check("ch2 strobe drop", 128'(upd_strobe), 128'(0));

    // Short scan on channel 0 -> sticky error; UIR clears flags only.
    scan(0, 32'hCAFEF00D, 32'h0F0F0F0F, 31, tw);
    step(S_UDR, 0);
    check("short no strobe", 128'(upd_strobe), 128'(0));
    check("short upd_data", 128'(upd_data[31:0]), 128'(0));
    check("short err", 128'(ir_out[0]), 128'(1));
    step(S_CIR, 0);
    step(S_UIR, 0);
    check("uir flags", 128'(ir_out[1:0]), 128'(0));
    check("uir upd_cnt", 128'(ir_out[9:2]), 128'(1));

    // Bypass: one-cycle delay of tdi.
    ir_in = 10'h3FF;
    step(S_CDR, 0);
    bt[0] = tdo; step(S_SDR, 1);
    bt[1] = tdo; step(S_SDR, 0);
    bt[2] = tdo; step(S_SDR, 1);
    bt[3] = tdo;
    check("bypass tdo", 128'(bt), 128'(4'b1010));
    step(S_E1, 0);
    step(S_UDR, 0);
    check("bypass no strobe", 128'(upd_strobe), 128'(0));
    check("bypass no err", 128'(ir_out), 128'(10'b100));

    // Paused scan on channel 3.
    tw = 32'hA5C30F96;
    ir_in = 3;
    cap_data[127:96] = 32'h0BADC0DE;
    step(S_CDR, 0);
    for (int i = 0; i < 16; i++) step(S_SDR, tw[i]);
    step(S_E1, 0);
    for (int i = 0; i < 5; i++) step(S_PDR, 0);
    step(S_E2, 0);
    for (int i = 16; i < 32; i++) step(S_SDR, tw[i]);
    step(S_E1, 0);
    step(S_UDR, 0);
    check("pause strobe", 128'(upd_strobe), 128'(4'b1000));
    check("pause upd_data", 128'(upd_data[127:96]), 128'(32'hA5C30F96));
    check("pause ir_out", 128'(ir_out), 128'(10'b1010));

    // Capture-only scan on channel 1.
    ir_in = 1;
    step(S_CDR, 0);
    step(S_E1, 0);
    step(S_UDR, 0);
    check("capture-only strobe", 128'(upd_strobe), 128'(0));
    check("capture-only ir_out", 128'(ir_out), 128'(10'b1010));

    // Over-long scan: data keeps shifting, update rejected.
    scan(1, 32'h11112222, 32'h33334444, 40, tw);
    step(S_UDR, 0);
    check("long no strobe", 128'(upd_strobe), 128'(0));
    check("long err", 128'(ir_out[0]), 128'(1));
    step(S_UIR, 0);

    // 254 more accepted updates wrap upd_cnt to 0.
    for (int n = 0; n < 254; n++) begin
      scan(n % NCH, 32'(n) * 32'h00010001, 32'(n) * 32'h01010101 ^ 32'h5A5A5A5A, 32, tw);
      step(S_UDR, 0);
    end
    step(S_IDLE, 0);
    check("wrap upd_cnt", 128'(ir_out[9:2]), 128'(0));
    check("wrap flags", 128'(ir_out[1:0]), 128'(2'b10));

    // Reset mid-scan aborts with no update.
    ir_in = 1;
    step(S_CDR, 0);
    for (int i = 0; i < 10; i++) step(S_SDR, 1);
    do_reset();
    check("abort upd_data", 128'(upd_data), 128'(0));
    check("abort ir_out", 128'(ir_out), 128'(0));
    check("abort tdo", 128'(tdo), 128'(0));
    step(S_IDLE, 0);
    step(S_UDR, 0);
    check("abort no strobe", 128'(upd_strobe), 128'(0));
    step(S_IDLE, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
